acs_ctrl: RTL and testbench

- Sequencer for the Viterbi ACS unit.
- Accepts one branch-metric symbol per handshake and sweeps ACSSegment 0..NSEG-1, driving Active, Init, CompareStart and Hold.
- Sits between the branch-metric unit and the ACS/metric-memory datapath.
- Closes each symbol with a one-cycle Hold so the lowest-state pick and survivors are latched.

---
 rtl/acs_ctrl.sv | 131 +++++++++++++
 tb/tb_acs_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_ctrl.sv
// acs_ctrl: per-symbol segment sequencer for the Viterbi ACS unit.
// Optional build macro ACSCTRL_BACKTOBACK_EN lets the next symbol be accepted during the Hold cycle.
module acs_ctrl #(
  parameter int WD_FSM = 6,
  parameter int NSEG   = 64
) (
  input  logic              Clock1,
  input  logic              Reset,
  input  logic              SymValid,
  output logic              SymReady,
  input  logic              FrameStart,
  input  logic              Stall,
  output logic              Active,
  output logic              Init,
  output logic              CompareStart,
  output logic              Hold,
  output logic [WD_FSM-1:0] ACSSegment,
  output logic              SymDone,
  output logic              Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // The pointer is one bit wider than the segment so it can reach NSEG.
  localparam logic [WD_FSM:0] LAST_NXT = (WD_FSM + 1)'(NSEG);
  localparam logic [WD_FSM:0] ONE_NXT  = (WD_FSM + 1)'(1);

  logic [1:0]        r_state;
  logic [WD_FSM:0]   r_nxt;
  logic              r_frame;
  logic              r_active;
  logic              r_init;
  logic              r_cstart;
  logic              r_hold;
  logic              r_done;
  logic              r_busy;
  logic [WD_FSM-1:0] r_seg;
  logic              w_accept;

`ifdef ACSCTRL_BACKTOBACK_EN
  assign SymReady = ((r_state == S_IDLE) | (r_state == S_HOLD)) & ~Stall & Reset;
`else
  assign SymReady = (r_state == S_IDLE) & ~Stall & Reset;
`endif

  assign w_accept = SymValid & SymReady;

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_nxt    <= '0;
      r_frame  <= 1'b0;
      r_active <= 1'b0;
      r_init   <= 1'b0;
      r_cstart <= 1'b0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_seg    <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees pre-edge state; strobes default low.
      r_active <= 1'b0;
      r_init   <= 1'b0;
      r_cstart <= 1'b0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_frame  <= FrameStart;
            r_seg    <= '0;
            r_active <= 1'b1;
            r_cstart <= 1'b1;
            r_init   <= FrameStart;
            r_nxt    <= ONE_NXT;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            if (r_nxt == LAST_NXT) begin
              r_state <= S_HOLD;
              r_hold  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_seg    <= r_nxt[WD_FSM-1:0];
              r_active <= 1'b1;
              r_init   <= r_frame;
              r_nxt    <= r_nxt + ONE_NXT;
            end
          end
        end
        S_HOLD: begin
`ifdef ACSCTRL_BACKTOBACK_EN
          if (w_accept) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_frame  <= FrameStart;
            r_seg    <= '0;
            r_active <= 1'b1;
            r_cstart <= 1'b1;
            r_init   <= FrameStart;
            r_nxt    <= ONE_NXT;
          end else
`endif
          begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_frame <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Active       = r_active;
  assign Init         = r_init;
  assign CompareStart = r_cstart;
  assign Hold         = r_hold;
  assign SymDone      = r_done;
  assign Busy         = r_busy;
  assign ACSSegment   = r_seg;

endmodule

// File: tb/tb_acs_ctrl.sv
// tb_acs_ctrl: directed and random checks of acs_ctrl against a cycle-level behavioural model.
// Honours ACSCTRL_BACKTOBACK_EN when the design is built with it.
module tb_acs_ctrl;
  localparam int WD_FSM = 6;
  localparam int NSEG   = 64;
`ifdef ACSCTRL_BACKTOBACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic Clock1     = 1'b0;
  logic Reset      = 1'b0;
  logic SymValid   = 1'b0;
  logic FrameStart = 1'b0;
  logic Stall      = 1'b0;
  logic SymReady, Active, Init, CompareStart, Hold, SymDone, Busy;
  logic [WD_FSM-1:0] ACSSegment;

  acs_ctrl #(.WD_FSM(WD_FSM), .NSEG(NSEG)) dut (
    .Clock1      (Clock1),
    .Reset       (Reset),
    .SymValid    (SymValid),
    .SymReady    (SymReady),
    .FrameStart  (FrameStart),
    .Stall       (Stall),
    .Active      (Active),
    .Init        (Init),
    .CompareStart(CompareStart),
    .Hold        (Hold),
    .ACSSegment  (ACSSegment),
    .SymDone     (SymDone),
    .Busy        (Busy)
  );

  always #5 Clock1 = ~Clock1;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: symbol in progress, how many segments issued, whether in the closing cycle.
  bit m_busy, m_hold, m_frame;
  int m_issued;
  logic e_active, e_init, e_cs, e_hold, e_done;
  logic [WD_FSM-1:0] e_seg;

  // Observation scoreboard and event timestamps (edge numbers).
  int  edge_n = 0, sb_next = 0, sb_count = 0, n_done = 0;
  int  t_cs = 0, t_cs_prev = 0, t_hold = 0, t_idle = 0;
  bit  busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return Reset && !Stall && (!m_busy || (B2B && m_hold));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_frame = 0; m_issued = 0;
    e_active = 0; e_init = 0; e_cs = 0; e_hold = 0; e_done = 0; e_seg = '0;
    sb_next = 0; sb_count = 0; busy_prev = 0;
  endtask

  task automatic model_start();
    m_busy = 1; m_hold = 0; m_issued = 1; m_frame = FrameStart;
    e_seg = '0; e_active = 1; e_cs = 1; e_init = FrameStart;
  endtask

  task automatic model_edge(input bit rdy);
    bit acc;
    acc = SymValid && rdy;
    e_active = 0; e_init = 0; e_cs = 0; e_hold = 0; e_done = 0;
    if (!m_busy) begin
      if (acc) model_start();
    end else if (m_hold) begin
      if (acc) model_start();
      else begin m_busy = 0; m_hold = 0; m_frame = 0; end
    end else if (!Stall) begin
      if (m_issued == NSEG) begin
        m_hold = 1; e_hold = 1; e_done = 1;
      end else begin
        e_seg = WD_FSM'(m_issued); e_active = 1; e_init = m_frame; m_issued++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".active"}, Active, e_active);
    check({tag, ".init"}, Init, e_init);
    check({tag, ".cstart"}, CompareStart, e_cs);
    check({tag, ".hold"}, Hold, e_hold);
    check({tag, ".symdone"}, SymDone, e_done);
    check({tag, ".seg"}, ACSSegment, e_seg);
    check({tag, ".busy"}, Busy, m_busy);
  endtask

  task automatic cycle();
    bit rdy;
    #1;
    rdy = model_ready();
    check("sym_ready", SymReady, rdy);
    @(posedge Clock1);
    edge_n++;
    model_edge(rdy);
    #1;
    check_outputs("cyc");
    if (Active) begin
      check("seg_order", ACSSegment, sb_next);
      sb_next++; sb_count++;
    end
    if (CompareStart) begin t_cs_prev = t_cs; t_cs = edge_n; end
    if (SymDone) begin
      check("active_per_sym", sb_count, NSEG);
      sb_next = 0; sb_count = 0; n_done++; t_hold = edge_n;
    end
    if (busy_prev && !Busy) t_idle = edge_n;
    busy_prev = Busy;
  endtask

  task automatic run_until_done(input int budget);
    int  start;
    bit  seen;
    start = n_done; seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (n_done > start) seen = 1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      cycle();
      if (!Busy) idle = 1;
    end
    check("idle_seen", idle, 1);
  endtask

  task automatic run_until_seg(input int seg, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (Active && ACSSegment == WD_FSM'(seg)) seen = 1;
    end
    check("seg_seen", seen, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, SymReady, 0);
    check({tag, ".active"}, Active, 0);
    check({tag, ".init"}, Init, 0);
    check({tag, ".cstart"}, CompareStart, 0);
    check({tag, ".hold"}, Hold, 0);
    check({tag, ".symdone"}, SymDone, 0);
    check({tag, ".seg"}, ACSSegment, 0);
    check({tag, ".busy"}, Busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, done0;
    bit found;
    model_reset();

    // Reset held for three cycles, then released with Stall low.
    repeat (3) begin
      @(posedge Clock1);
      #1;
      check_all_zero("reset");
    end
    #1;
    Reset = 1'b1;
    cycle();

    // One symbol, FrameStart=1, no stalls.
    SymValid = 1; FrameStart = 1;
    cycle();
    check("t2_accept_cs", CompareStart, 1);
    SymValid = 0; FrameStart = 0;
    run_until_done(NSEG + 10);
    check("t2_hold_latency", t_hold - t_cs, NSEG);
    cycle();
    check("t2_idle_latency", t_idle - t_cs, NSEG + 1);

    // Two symbols with SymValid held high; only the first is a frame start.
    SymValid = 1; FrameStart = 1;
    cycle();
    FrameStart = 0;
    c0 = t_cs; found = 0;
    for (int i = 0; i < 3 * NSEG && !found; i++) begin
      cycle();
      if (t_cs != c0) found = 1;
    end
    check("t3_second_seen", found, 1);
    check("t3_period", t_cs - t_cs_prev, B2B ? NSEG + 1 : NSEG + 2);
    check("t3_init_second", Init, 0);
    SymValid = 0;
    run_until_done(NSEG + 10);
    wait_idle(10);

    // Stall for 3 cycles after segment 10, 1 cycle after segment 63.
    SymValid = 1;
    cycle();
    SymValid = 0;
    run_until_seg(10, NSEG);
    Stall = 1;
    repeat (3) cycle();
    check("t4_seg_held", ACSSegment, 10);
    Stall = 0;
    run_until_seg(NSEG - 1, NSEG + 10);
    Stall = 1;
    cycle();
    Stall = 0;
    run_until_done(10);
    check("t4_hold_latency", t_hold - t_cs, NSEG + 4);
    wait_idle(10);

    // Asynchronous reset mid-symbol while segment 30 is issued.
    SymValid = 1;
    cycle();
    SymValid = 0;
    run_until_seg(30, NSEG);
    done0 = n_done;
    #2;
    Reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    repeat (2) begin
      @(posedge Clock1);
      #1;
      check_all_zero("reset_hold");
    end
    Reset = 1'b1;
    SymValid = 1;
    cycle();
    check("t5_restart_seg", ACSSegment, 0);
    check("t5_restart_cs", CompareStart, 1);
    check("t5_no_symdone", n_done, done0);
    SymValid = 0;
    run_until_done(NSEG + 10);
    wait_idle(10);

    // Stall in IDLE blocks the handshake; release accepts on the next edge.
    Stall = 1; SymValid = 1;
    repeat (3) cycle();
    check("t6_no_accept", Busy, 0);
    Stall = 0;
    cycle();
    check("t6_accept_seg0", {Active, CompareStart, ACSSegment}, {2'b11, 6'd0});
    SymValid = 0;
    run_until_done(NSEG + 10);
    wait_idle(10);

    // Random traffic with random stalls and frame flags.
    repeat (1500) begin
      SymValid   = 1'($urandom_range(0, 1));
      FrameStart = 1'($urandom_range(0, 1));
      Stall      = ($urandom_range(0, 3) == 0);
      cycle();
    end
    SymValid = 0; Stall = 0;
    wait_idle(2 * NSEG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
